// File: rtl/iq_shot_accumulator.sv
// Multi-shot I/Q integrator: triggered delay, integration window and per-channel
// saturating accumulation over several shots, then a channel-by-channel
// valid/ready readout of the raw (undivided) sums.
module iq_shot_accumulator #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned LANES  = 5,
  parameter int unsigned IN_W   = 32,
  parameter int unsigned ACC_W  = 48,
  parameter int unsigned DLY_W  = 14,
  parameter int unsigned LEN_W  = 11,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                            clk100,
  input  logic                            reset_n,
  input  logic                            trigger,
  input  logic [DLY_W-1:0]                cfg_delay,
  input  logic [LEN_W-1:0]                cfg_length,
  input  logic [7:0]                      cfg_shots,
  input  logic [NUM_CH*LANES*IN_W-1:0]    din_i,
  input  logic [NUM_CH*LANES*IN_W-1:0]    din_q,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [CH_W-1:0]                 res_ch,
  output logic signed [ACC_W-1:0]         res_i,
  output logic signed [ACC_W-1:0]         res_q,
  output logic                            res_sat,
  output logic                            busy,
  output logic                            missed_trig
);

  // Lane sums and the pre-clamp total get headroom so neither can wrap.
  localparam int unsigned SUM_W = IN_W + $clog2(LANES) + 1;
  localparam int unsigned EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam int unsigned CNT_W = (DLY_W > LEN_W) ? DLY_W : LEN_W;

  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] ExtMax = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] ExtMin = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StArmed, StDelay, StIntegrate, StOutput} state_e;

  state_e                  state_q;
  logic                    trig_q;
  logic [DLY_W-1:0]        dly_q;
  logic [LEN_W-1:0]        len_q;
  logic [7:0]              shots_q;
  logic [7:0]              shot_cnt_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    res_valid_q;
  logic [CH_W-1:0]         res_ch_q;
  logic signed [ACC_W-1:0] res_i_q;
  logic signed [ACC_W-1:0] res_q_q;
  logic                    res_sat_q;
  logic                    missed_q;

  logic signed [ACC_W-1:0] acc_i_q [NUM_CH];
  logic signed [ACC_W-1:0] acc_q_q [NUM_CH];
  logic [NUM_CH-1:0]       sat_q;

  logic                    trig_edge;
  logic                    last_ch;
  logic                    out_accept;
  logic                    acc_en;
  logic                    acc_clr;
  logic [CH_W-1:0]         nxt_ch;
  logic [DLY_W-1:0]        dly_sel;
  logic [LEN_W-1:0]        len_sel;
  logic [CNT_W-1:0]        len_m1;
  logic [8:0]              shots_eff;
  logic [8:0]              shot_nxt;

  logic signed [EXT_W-1:0] sum_i [NUM_CH];
  logic signed [EXT_W-1:0] sum_q [NUM_CH];
  logic signed [ACC_W-1:0] nxt_i [NUM_CH];
  logic signed [ACC_W-1:0] nxt_q [NUM_CH];
  logic [NUM_CH-1:0]       hit_i;
  logic [NUM_CH-1:0]       hit_q;

  function automatic logic signed [EXT_W-1:0] sext_in(logic [IN_W-1:0] v);
    return {{(EXT_W-IN_W){v[IN_W-1]}}, v};
  endfunction

  // Returns {saturated, clamped_sum}.
  function automatic logic [ACC_W:0] sat_add(logic signed [ACC_W-1:0] acc,
                                             logic signed [EXT_W-1:0] inc);
    logic signed [EXT_W-1:0] tot;
    tot = {{(EXT_W-ACC_W){acc[ACC_W-1]}}, acc} + inc;
    if (tot > ExtMax) begin
      return {1'b1, AccMax};
    end else if (tot < ExtMin) begin
      return {1'b1, AccMin};
    end
    return {1'b0, tot[ACC_W-1:0]};
  endfunction

  // Control decode; cfg comes straight from the ports only while idle.
  always_comb begin
    trig_edge  = trigger & ~trig_q;
    last_ch    = (res_ch_q == CH_W'(NUM_CH - 1));
    nxt_ch     = res_ch_q + CH_W'(1);
    out_accept = (state_q == StOutput) & res_valid_q & res_ready;
    acc_en     = (state_q == StIntegrate);
    acc_clr    = out_accept & last_ch;
    dly_sel    = (state_q == StIdle) ? cfg_delay : dly_q;
    len_sel    = (state_q == StIdle) ? cfg_length : len_q;
    len_m1     = (len_sel == '0) ? '0 : CNT_W'(len_sel) - CNT_W'(1);
    shots_eff  = (shots_q == 8'd0) ? 9'd1 : {1'b0, shots_q};
    shot_nxt   = {1'b0, shot_cnt_q} + 9'd1;
  end

  // Per-channel lane sums and saturating next accumulator values.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      sum_i[c] = '0;
      sum_q[c] = '0;
      for (int l = 0; l < LANES; l++) begin
        sum_i[c] = sum_i[c] + sext_in(din_i[(c*LANES+l)*IN_W +: IN_W]);
        sum_q[c] = sum_q[c] + sext_in(din_q[(c*LANES+l)*IN_W +: IN_W]);
      end
      {hit_i[c], nxt_i[c]} = sat_add(acc_i_q[c], sum_i[c]);
      {hit_q[c], nxt_q[c]} = sat_add(acc_q_q[c], sum_q[c]);
    end
  end

  // Shot sequencing FSM with registered result and missed-trigger outputs.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      trig_q      <= 1'b0;
      dly_q       <= '0;
      len_q       <= '0;
      shots_q     <= '0;
      shot_cnt_q  <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_i_q     <= '0;
      res_q_q     <= '0;
      res_sat_q   <= 1'b0;
      missed_q    <= 1'b0;
    end else begin
      trig_q   <= trigger;
      missed_q <= trig_edge & ((state_q == StDelay) | (state_q == StIntegrate) |
                               (state_q == StOutput));
      case (state_q)
        StIdle, StArmed: begin
          if (trig_edge) begin
            if (state_q == StIdle) begin
              dly_q      <= cfg_delay;
              len_q      <= cfg_length;
              shots_q    <= cfg_shots;
              shot_cnt_q <= '0;
            end
            if (dly_sel == '0) begin
              state_q <= StIntegrate;
              cnt_q   <= len_m1;
            end else begin
              state_q <= StDelay;
              cnt_q   <= CNT_W'(dly_sel) - CNT_W'(1);
            end
          end
        end
        StDelay: begin
          if (cnt_q == '0) begin
            state_q <= StIntegrate;
            cnt_q   <= len_m1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StIntegrate: begin
          if (cnt_q == '0) begin
            shot_cnt_q <= shot_nxt[7:0];
            if (shot_nxt < shots_eff) begin
              state_q <= StArmed;
            end else begin
              state_q  <= StOutput;
              res_ch_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StOutput: begin
          // First cycle in OUTPUT loads channel 0; later words load on acceptance.
          if (!res_valid_q) begin
            res_valid_q <= 1'b1;
            res_i_q     <= acc_i_q[res_ch_q];
            res_q_q     <= acc_q_q[res_ch_q];
            res_sat_q   <= sat_q[res_ch_q];
          end else if (res_ready) begin
            if (last_ch) begin
              state_q     <= StIdle;
              res_valid_q <= 1'b0;
              res_ch_q    <= '0;
              res_i_q     <= '0;
              res_q_q     <= '0;
              res_sat_q   <= 1'b0;
            end else begin
              res_ch_q  <= nxt_ch;
              res_i_q   <= acc_i_q[nxt_ch];
              res_q_q   <= acc_q_q[nxt_ch];
              res_sat_q <= sat_q[nxt_ch];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Accumulators and sticky saturation flags, cleared once the last word is taken.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_i_q[c] <= '0;
        acc_q_q[c] <= '0;
      end
      sat_q <= '0;
    end else if (acc_clr) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_i_q[c] <= '0;
        acc_q_q[c] <= '0;
      end
      sat_q <= '0;
    end else if (acc_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_i_q[c] <= nxt_i[c];
        acc_q_q[c] <= nxt_q[c];
      end
      sat_q <= sat_q | hit_i | hit_q;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_ch      = res_ch_q;
  assign res_i       = res_i_q;
  assign res_q       = res_q_q;
  assign res_sat     = res_sat_q;
  assign busy        = (state_q != StIdle);
  assign missed_trig = missed_q;

endmodule

// File: tb/tb_iq_shot_accumulator.sv
// Scoreboard bench: two instances (wide and narrow accumulator) see identical
// stimulus; a shot-level reference model predicts each result word.
module tb_iq_shot_accumulator;

  localparam int NUM_CH = 2;
  localparam int LANES  = 5;
  localparam int IN_W   = 32;
  localparam int VW     = NUM_CH * LANES * IN_W;

  logic clk = 1'b0;
  logic reset_n, trigger, res_ready;
  logic [13:0] cfg_delay;
  logic [10:0] cfg_length;
  logic [7:0]  cfg_shots;
  logic [VW-1:0] din_i, din_q;

  logic res_valid_a, res_sat_a, busy_a, missed_a;
  logic [0:0] res_ch_a;
  logic signed [47:0] res_i_a, res_q_a;
  logic res_valid_b, res_sat_b, busy_b, missed_b;
  logic [0:0] res_ch_b;
  logic signed [33:0] res_i_b, res_q_b;

  always #5 clk = ~clk;

  iq_shot_accumulator u_dut_a (
    .clk100(clk), .reset_n(reset_n), .trigger(trigger), .cfg_delay(cfg_delay),
    .cfg_length(cfg_length), .cfg_shots(cfg_shots), .din_i(din_i), .din_q(din_q),
    .res_valid(res_valid_a), .res_ready(res_ready), .res_ch(res_ch_a), .res_i(res_i_a),
    .res_q(res_q_a), .res_sat(res_sat_a), .busy(busy_a), .missed_trig(missed_a)
  );

  iq_shot_accumulator #(.ACC_W(34)) u_dut_b (
    .clk100(clk), .reset_n(reset_n), .trigger(trigger), .cfg_delay(cfg_delay),
    .cfg_length(cfg_length), .cfg_shots(cfg_shots), .din_i(din_i), .din_q(din_q),
    .res_valid(res_valid_b), .res_ready(res_ready), .res_ch(res_ch_b), .res_i(res_i_b),
    .res_q(res_q_b), .res_sat(res_sat_b), .busy(busy_b), .missed_trig(missed_b)
  );

  typedef struct {int ch; longint i; longint q; bit sat;} exp_t;
  exp_t qa[$];
  exp_t qb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int miss_a = 0, miss_b = 0, miss_exp = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by stimulus

  // Reference model: per-instance, per-channel clamped running sums.
  int     acc_w [2] = '{48, 34};
  longint m_i [2][NUM_CH];
  longint m_q [2][NUM_CH];
  bit     m_s [2][NUM_CH];
  longint cur_si [NUM_CH];
  longint cur_sq [NUM_CH];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic longint clampw(input longint v, input int w);
    longint mx, mn;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    return (v > mx) ? mx : ((v < mn) ? mn : v);
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NUM_CH; c++) begin
        m_i[d][c] = 0; m_q[d][c] = 0; m_s[d][c] = 0;
      end
  endtask

  task automatic model_add();
    longint ti, tq;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NUM_CH; c++) begin
        ti = m_i[d][c] + cur_si[c];
        tq = m_q[d][c] + cur_sq[c];
        m_i[d][c] = clampw(ti, acc_w[d]);
        m_q[d][c] = clampw(tq, acc_w[d]);
        if (m_i[d][c] != ti || m_q[d][c] != tq) m_s[d][c] = 1;
      end
  endtask

  task automatic model_push();
    for (int c = 0; c < NUM_CH; c++) begin
      qa.push_back('{c, m_i[0][c], m_q[0][c], m_s[0][c]});
      qb.push_back('{c, m_i[1][c], m_q[1][c], m_s[1][c]});
    end
    model_clear();
  endtask

  task automatic drive_samples(input int mode);
    int vi, vq;
    for (int c = 0; c < NUM_CH; c++) begin
      cur_si[c] = 0; cur_sq[c] = 0;
      for (int l = 0; l < LANES; l++) begin
        case (mode)
          0: begin vi = int'($urandom); vq = int'($urandom); end
          1: begin vi = 1; vq = -2; end
          2: begin vi = 32'h7fffffff; vq = 32'h7fffffff; end
          3: begin vi = int'($urandom_range(0, 2000)) - 1000; vq = int'($urandom_range(0, 99)); end
          default: begin vi = 32'h80000000; vq = int'($urandom); end
        endcase
        din_i[(c*LANES+l)*IN_W +: IN_W] = vi;
        din_q[(c*LANES+l)*IN_W +: IN_W] = vq;
        cur_si[c] += longint'(vi);
        cur_sq[c] += longint'(vq);
      end
    end
  endtask

  // Monitors: pop and compare whenever a word is accepted.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && res_valid_a && res_ready) begin
      if (qa.size() == 0) chk("a_unexpected_word", qa.size(), 1);
      else begin
        e = qa.pop_front();
        chk("a_ch", res_ch_a, e.ch);
        chk("a_res_i", longint'(res_i_a), e.i);
        chk("a_res_q", longint'(res_q_a), e.q);
        chk("a_res_sat", res_sat_a, e.sat);
      end
    end
    if (missed_a) miss_a++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && res_valid_b && res_ready) begin
      if (qb.size() == 0) chk("b_unexpected_word", qb.size(), 1);
      else begin
        e = qb.pop_front();
        chk("b_ch", res_ch_b, e.ch);
        chk("b_res_i", longint'(res_i_b), e.i);
        chk("b_res_q", longint'(res_q_b), e.q);
        chk("b_res_sat", res_sat_b, e.sat);
      end
    end
    if (missed_b) miss_b++;
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 1) res_ready = 1'($urandom_range(0, 1));
      else if (rdy_mode == 0) res_ready = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, res_valid_a, 0);
    chk({tag, "_ch"}, res_ch_a, 0);
    chk({tag, "_res_i"}, longint'(res_i_a), 0);
    chk({tag, "_res_q"}, longint'(res_q_a), 0);
    chk({tag, "_sat"}, res_sat_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_missed"}, missed_a, 0);
    chk({tag, "_b_busy_valid"}, {busy_b, res_valid_b, res_sat_b}, 0);
  endtask

  task automatic drain(input bit hold, input bit coinc);
    int prev_mode;
    bit done, idle;
    logic [47:0] ci;
    logic [33:0] cb;
    logic cs;
    @(posedge clk); #1;
    trigger = 1'b0;
    if (hold) begin
      prev_mode = rdy_mode;
      rdy_mode  = 2;
      res_ready = 1'b0;
      for (int t = 0; t < 50 && !res_valid_a; t++) begin @(posedge clk); #1; end
      chk("hold_valid", res_valid_a, 1);
      chk("hold_ch0", res_ch_a, 0);
      ci = res_i_a; cb = res_i_b; cs = res_sat_a;
      for (int t = 0; t < 5; t++) begin
        @(posedge clk); #1;
        chk("hold_valid_stable", res_valid_a, 1);
        chk("hold_ch_stable", res_ch_a, 0);
        chk("hold_i_stable", longint'(res_i_a), longint'($signed(ci)));
        chk("hold_b_i_stable", longint'(res_i_b), longint'($signed(cb)));
        chk("hold_sat_stable", res_sat_a, cs);
      end
      res_ready = 1'b1;
      rdy_mode  = prev_mode;
    end
    done = 0;
    idle = 0;
    for (int t = 0; t < 300 && !idle; t++) begin
      @(posedge clk); #1;
      if (coinc && !done && res_valid_a && res_ready && res_ch_a == 1'(NUM_CH - 1)) begin
        trigger = 1'b1;
        miss_exp++;
        done = 1;
      end else begin
        trigger = 1'b0;
        if (!busy_a && !busy_b) idle = 1;
      end
    end
    chk("drain_reached_idle", idle, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("idle_busy_a", busy_a, 0);
    chk("idle_busy_b", busy_b, 0);
    chk("idle_valid", res_valid_a, 0);
    chk("scoreboard_a_empty", qa.size(), 0);
    chk("scoreboard_b_empty", qb.size(), 0);
    chk("missed_count_a", miss_a, miss_exp);
    chk("missed_count_b", miss_b, miss_exp);
  endtask

  // One complete result: se shots, then the readout drain.
  task automatic run(input int d, input int l, input int s, input int mode,
                     input bit mid_miss, input bit hold, input bit coinc, input bit do_rst);
    int le, se;
    le = (l == 0) ? 1 : l;
    se = (s == 0) ? 1 : s;
    for (int sh = 0; sh < se; sh++) begin
      @(posedge clk); #1;
      if (sh == 0) begin
        cfg_delay = 14'(d); cfg_length = 11'(l); cfg_shots = 8'(s);
      end
      trigger = 1'b1;
      drive_samples(mode);
      for (int k = 1; k <= d + le; k++) begin
        @(posedge clk); #1;
        trigger = 1'b0;
        if (k == 1) begin
          cfg_delay = 14'($urandom); cfg_length = 11'($urandom); cfg_shots = 8'($urandom);
        end
        if (do_rst && k == d + 1) begin
          reset_n = 1'b0;
          #1;
          check_zero_outputs("in_reset");
          repeat (2) @(posedge clk);
          #1;
          reset_n = 1'b1;
          model_clear();
          return;
        end
        if (mid_miss && k >= 2 && (k == d + le || (k == 2 && d >= 3))) begin
          trigger = 1'b1;
          miss_exp++;
        end
        drive_samples(mode);
        if (k > d) model_add();
      end
      if (sh < se - 1) begin
        repeat (2 + $urandom_range(0, 3)) begin
          @(posedge clk); #1;
          trigger = 1'b0;
          drive_samples(mode);
          chk("armed_busy_a", busy_a, 1);
          chk("armed_busy_b", busy_b, 1);
        end
      end else begin
        model_push();
      end
    end
    drain(hold, coinc);
  endtask

  initial begin
    reset_n = 1'b0; trigger = 1'b0; res_ready = 1'b1;
    cfg_delay = '0; cfg_length = '0; cfg_shots = '0;
    din_i = '0; din_q = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_busy", busy_a, 0);

    rdy_mode = 0;
    run(3, 4, 1, 1, 0, 0, 0, 0);     // +1/-2 constants: 20 / -40 per channel
    run(2, 2, 3, 1, 0, 0, 0, 0);     // three shots: 30 per channel
    run(1, 3, 1, 0, 0, 1, 0, 0);     // backpressure hold
    run(0, 8, 1, 2, 0, 0, 0, 0);     // narrow instance saturates positive
    run(2, 2, 1, 3, 0, 0, 0, 0);     // sat flag cleared on next run
    run(1, 4, 1, 4, 0, 0, 0, 0);     // narrow instance saturates negative
    run(4, 5, 2, 3, 1, 0, 1, 0);     // missed edges mid-run and on final accept
    run(2, 6, 1, 0, 0, 0, 0, 1);     // reset mid-integrate, no result
    run(1, 3, 1, 0, 0, 0, 0, 0);     // fresh shot after reset
    run(0, 0, 0, 0, 0, 0, 0, 0);     // zero length/shots treated as one

    for (int r = 0; r < 8; r++) begin
      rdy_mode = int'($urandom_range(0, 1));
      run(int'($urandom_range(0, 5)), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
          (r % 3 == 0) ? 0 : ((r % 3 == 1) ? 3 : 4), 1'($urandom_range(0, 1)), 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
